// File: rtl/dcounter_pkg.sv
// Shared types and default widths for the dcounter scheduler and its arbiter.
package dcounter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        RESP   = 3'd4
    } state_e;

    localparam int DEF_NREQ = 4;
    localparam int DEF_CW   = 16;
    localparam int DEF_LW   = 16;

endpackage

// File: rtl/dcounter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and wraps once
// around the request vector; the pointer itself lives in the parent.
module rr_arbiter
    import dcounter_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);

    logic           w_found;
    int             w_cand;
    logic [IDW-1:0] w_candIdx;

    // First requester at or after i_ptr (modulo NREQ) wins.
    always_comb begin
        o_grant   = '0;
        o_idx     = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        w_candIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            w_candIdx = IDW'(w_cand);
            if (i_en && !w_found && i_req[w_candIdx]) begin
                w_found            = 1'b1;
                o_grant[w_candIdx] = 1'b1;
                o_idx              = w_candIdx;
            end
        end
    end

endmodule

// File: rtl/dcounter_sched.sv
// Round-robin scheduler sharing one dcounter among NREQ requesters: each job is
// an optional clear, LEN enable cycles, then a tagged sample of the counter.
module dcounter_sched
    import dcounter_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int CW   = DEF_CW,
    parameter  int LW   = DEF_LW,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*LW-1:0] req_len,
    input  logic [NREQ-1:0]  req_clr,
    output logic [NREQ-1:0]  req_ready,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [CW-1:0]    rsp_data,
    input  logic             rsp_ready,
    output logic             cnt_en,
    output logic             cnt_clr,
    input  logic [CW-1:0]    cnt_val,
    output logic             busy
);

    state_e          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [LW-1:0]   r_remain;
    logic            r_cntEn;
    logic            r_cntClr;
    logic            r_rspValid;
    logic [IDW-1:0]  r_rspId;
    logic [CW-1:0]   r_rspData;
    logic            r_rstDly;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_winIdx;
    logic            w_arbEn;
    logic            w_accept;
    logic [LW-1:0]   w_winLen;
    logic            w_winClr;
    logic [IDW-1:0]  w_nextPtr;

    // Grants are withheld during reset and the first cycle after it.
    assign w_arbEn = (r_state == IDLE) && !rst && !r_rstDly;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_arbEn),
        .o_grant (w_grant),
        .o_idx   (w_winIdx)
    );

    assign w_accept  = |w_grant;
    assign w_winClr  = |(req_clr & w_grant);
    assign w_nextPtr = (w_winIdx == IDW'(NREQ - 1)) ? '0 : w_winIdx + 1'b1;

    always_comb begin
        w_winLen = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_winLen = req_len[i*LW +: LW];
            end
        end
    end

    // r_remain carries the job length through CLEAR and counts down in RUN.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_id       <= '0;
            r_remain   <= '0;
            r_cntEn    <= 1'b0;
            r_cntClr   <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspId    <= '0;
            r_rspData  <= '0;
            r_rstDly   <= 1'b1;
        end else begin
            r_rstDly <= 1'b0;
            r_cntEn  <= 1'b0;
            r_cntClr <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id     <= w_winIdx;
                        r_remain <= w_winLen;
                        r_ptr    <= w_nextPtr;
                        if (w_winClr) begin
                            r_state  <= CLEAR;
                            r_cntClr <= 1'b1;
                        end else if (w_winLen != '0) begin
                            r_state <= RUN;
                            r_cntEn <= 1'b1;
                        end else begin
                            r_state <= SETTLE;
                        end
                    end
                end
                CLEAR: begin
                    if (r_remain != '0) begin
                        r_state <= RUN;
                        r_cntEn <= 1'b1;
                    end else begin
                        r_state <= SETTLE;
                    end
                end
                RUN: begin
                    if (r_remain == LW'(1)) begin
                        r_state <= SETTLE;
                    end else begin
                        r_remain <= r_remain - LW'(1);
                        r_cntEn  <= 1'b1;
                    end
                end
                SETTLE: begin
                    r_rspData  <= cnt_val;
                    r_rspId    <= r_id;
                    r_rspValid <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rspValid;
    assign rsp_id    = r_rspId;
    assign rsp_data  = r_rspData;
    assign cnt_en    = r_cntEn;
    assign cnt_clr   = r_cntClr;
    assign busy      = (r_state != IDLE);

    // A requester may not withdraw a request before it is accepted.
    for (genvar g = 0; g < NREQ; g++) begin : g_holdChk
        a_holdValid: assert property (@(posedge clock) disable iff (rst)
            (req_valid[g] && !req_ready[g]) |=> req_valid[g]);
    end

endmodule
